// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: one line request becomes one INCR burst of LINE_WORDS beats.
// Read beats are gathered into a line register; completion is a one-cycle response pulse.
module axi_line_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
  output logic                             resp_valid,
  output logic                             resp_err,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
  output logic [ID_WIDTH-1:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]            m_axi_awaddr,
  output logic [7:0]                       m_axi_awlen,
  output logic [2:0]                       m_axi_awsize,
  output logic [1:0]                       m_axi_awburst,
  output logic                             m_axi_awlock,
  output logic [3:0]                       m_axi_awcache,
  output logic [2:0]                       m_axi_awprot,
  output logic                             m_axi_awvalid,
  input  logic                             m_axi_awready,
  output logic [DATA_WIDTH-1:0]            m_axi_wdata,
  output logic [STRB_WIDTH-1:0]            m_axi_wstrb,
  output logic                             m_axi_wlast,
  output logic                             m_axi_wvalid,
  input  logic                             m_axi_wready,
  input  logic [ID_WIDTH-1:0]              m_axi_bid,
  input  logic [1:0]                       m_axi_bresp,
  input  logic                             m_axi_bvalid,
  output logic                             m_axi_bready,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arlock,
  output logic [3:0]                       m_axi_arcache,
  output logic [2:0]                       m_axi_arprot,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(LINE_WORDS * STRB_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;
  logic r_req_ready, w_req_ready_nxt;
  logic r_resp_valid, w_resp_valid_nxt;
  logic r_resp_err, w_resp_err_nxt;
  logic r_err, w_err_nxt;
  logic r_arvalid, w_arvalid_nxt;
  logic r_rready, w_rready_nxt;
  logic r_awvalid, w_awvalid_nxt;
  logic r_wvalid, w_wvalid_nxt;
  logic r_bready, w_bready_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_wline, w_wline_nxt;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] r_rline, w_rline_nxt;

  logic w_aw_hs, w_w_hs, w_last, w_unused;

  assign w_aw_hs  = r_awvalid & m_axi_awready;
  assign w_w_hs   = r_wvalid & m_axi_wready;
  assign w_last   = (r_cnt == LAST_BEAT);
  assign w_unused = ^{m_axi_rid, m_axi_bid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_err        <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wline      <= '0;
      r_rline      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_err        <= w_err_nxt;
      r_arvalid    <= w_arvalid_nxt;
      r_rready     <= w_rready_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_cnt        <= w_cnt_nxt;
      r_addr       <= w_addr_nxt;
      r_wline      <= w_wline_nxt;
      r_rline      <= w_rline_nxt;
    end
  end

  // Every output is the registered image of a next-state value, so inputs never reach outputs combinationally.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_err_nxt        = r_err;
    w_arvalid_nxt    = r_arvalid;
    w_rready_nxt     = r_rready;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_cnt_nxt        = r_cnt;
    w_addr_nxt       = r_addr;
    w_wline_nxt      = r_wline;
    w_rline_nxt      = r_rline;
    case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt = 1'b0;
          w_addr_nxt      = req_addr & ADDR_MASK;
          w_wline_nxt     = req_wdata;
          w_err_nxt       = 1'b0;
          w_cnt_nxt       = '0;
          if (req_we) begin
            w_state_nxt   = S_WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = S_RD_ADDR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      S_RD_ADDR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        // The beat count ends the burst; rlast is only cross-checked against it.
        if (m_axi_rvalid) begin
          w_rline_nxt[r_cnt] = m_axi_rdata;
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_last)) w_err_nxt = 1'b1;
          if (w_last) begin
            w_rready_nxt     = 1'b0;
            w_state_nxt      = S_DONE;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = w_err_nxt;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_WR: begin
        if (w_aw_hs) w_awvalid_nxt = 1'b0;
        if (w_w_hs) begin
          if (w_last) w_wvalid_nxt = 1'b0;
          else        w_cnt_nxt    = r_cnt + 1'b1;
        end
        // A dropped valid means that channel already finished.
        if ((!r_awvalid || w_aw_hs) && (!r_wvalid || (w_w_hs && w_last))) begin
          w_state_nxt  = S_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_nxt     = 1'b0;
          w_err_nxt        = r_err | (m_axi_bresp != 2'b00);
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = w_err_nxt;
          w_state_nxt      = S_DONE;
        end
      end
      S_DONE: begin
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_err      = r_resp_err;
  assign resp_rdata    = r_rline;

  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'(LINE_WORDS - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wline[r_cnt];
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_last;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'($clog2(STRB_WIDTH));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_line_master.sv
// Bench for axi_line_master: AXI slave with a word memory and stall/error knobs,
// and a line-level reference memory that predicts read lines and error flags.
module tb_axi_line_master;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int IW = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic req_valid, req_ready, req_we, resp_valid, resp_err;
  logic [AW-1:0] req_addr;
  logic [LW*DW-1:0] req_wdata, resp_rdata;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, arcache;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;

  axi_line_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW),
                    .AXI_ID(0), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] smem    [0:4095];
  logic [31:0] ref_mem [0:4095];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < LW; i++) l[i*32 +: 32] = ref_mem[widx(base + 32'(i*4))];
    return l;
  endfunction

  int aw_delay = 0, ar_delay = 0, rerr_beat = -1, early_beat = -1;
  bit w_toggle = 0, aw_after_w = 0, rand_stall = 0;
  logic [1:0] bresp_val = 2'b00;
  logic [31:0] exp_addr = 0;
  logic [127:0] exp_wline = 0;
  logic [127:0] last_rd_line = 0;
  int rbeat = 0, rhs = 0, pulses = 0;
  int last_acc_edge = 0, last_resp_edge = 0;

  // Read slave
  initial begin
    logic [31:0] raddr;
    bit hs_ar, hs_r, active;
    int arw;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    active = 0; arw = 0; raddr = 0;
    forever begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_r  = rvalid && rready;
      if (hs_ar) begin
        chk("araddr", araddr, exp_addr);
        chk("arlen", arlen, 3);
        chk("arsize_burst", {arsize, arburst}, {3'd2, 2'b01});
      end
      @(posedge clk); #1;
      if (!rst_n) begin
        arready = 0; rvalid = 0; rlast = 0; active = 0; arw = 0; rbeat = 0;
        continue;
      end
      if (hs_ar) begin raddr = araddr; rbeat = 0; active = 1; arw = 0; end
      if (hs_r) begin
        rhs++;
        rbeat++;
        if (rbeat == LW) active = 0;
      end
      arready = arvalid && !active && (arw >= ar_delay) && (!rand_stall || ($urandom % 2 == 1));
      if (arvalid) arw++;
      if (!(rvalid && !hs_r)) begin
        if (active && rbeat < LW && (!rand_stall || $urandom_range(0, 2) != 0)) begin
          rvalid = 1;
          rdata  = smem[widx(raddr + 32'(rbeat*4))];
          rresp  = (rbeat == rerr_beat) ? 2'b10 : 2'b00;
          rlast  = (rbeat == LW-1) || (rbeat == early_beat);
        end else begin
          rvalid = 0; rlast = 0; rresp = 0;
        end
      end
    end
  end

  // Write slave
  initial begin
    bit hs_aw, hs_w, hs_b, aw_got, wph, bready_q;
    logic [31:0] waddr, aw_l, wd_l;
    int wbeat, aww;
    logic [127:0] wbuf;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    aw_got = 0; wph = 0; bready_q = 0; waddr = 0; wbeat = 0; aww = 0; wbuf = 0;
    forever begin
      @(negedge clk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      aw_l  = awaddr;
      wd_l  = wdata;
      if (hs_aw) begin
        chk("awaddr", awaddr, exp_addr);
        chk("awlen", awlen, 3);
      end
      if (hs_w) chk("wlast", wlast, wbeat == LW-1);
      if (bready && !bready_q) chk("bready_after_aw", aw_got, 1);
      bready_q = bready;
      @(posedge clk); #1;
      if (!rst_n) begin
        awready = 0; wready = 0; bvalid = 0; aw_got = 0; wbeat = 0; aww = 0; bready_q = 0;
        continue;
      end
      if (hs_aw) begin aw_got = 1; waddr = aw_l; aww = 0; end
      if (hs_w && wbeat < LW) begin wbuf[wbeat*32 +: 32] = wd_l; wbeat++; end
      if (hs_b) begin
        bvalid = 0; aw_got = 0; wbeat = 0;
      end else if (aw_got && wbeat == LW && !bvalid) begin
        chk("w_line", wbuf, exp_wline);
        for (int i = 0; i < LW; i++) smem[widx(waddr + 32'(i*4))] = wbuf[i*32 +: 32];
        bvalid = 1;
        bresp  = bresp_val;
      end
      awready = awvalid && !aw_got && (aww >= aw_delay) && (!aw_after_w || wbeat == LW) &&
                (!rand_stall || ($urandom % 2 == 1));
      if (awvalid && !aw_got) aww++;
      wph = ~wph;
      wready = w_toggle ? wph : (rand_stall ? 1'($urandom % 2) : 1'b1);
    end
  end

  // Valid/payload stability and response pulse counting
  initial begin
    logic [32:0] aw_q, ar_q;
    logic [33:0] w_q;
    bit aw_st, w_st, ar_st;
    aw_st = 0; w_st = 0; ar_st = 0; aw_q = 0; ar_q = 0; w_q = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin aw_st = 0; w_st = 0; ar_st = 0; continue; end
      if (aw_st) chk("aw_stable", {awvalid, awaddr}, aw_q);
      if (w_st)  chk("w_stable", {wvalid, wlast, wdata}, w_q);
      if (ar_st) chk("ar_stable", {arvalid, araddr}, ar_q);
      aw_st = awvalid && !awready; aw_q = {awvalid, awaddr};
      w_st  = wvalid && !wready;   w_q  = {wvalid, wlast, wdata};
      ar_st = arvalid && !arready; ar_q = {arvalid, araddr};
      if (resp_valid) pulses++;
    end
  end

  // Called at a negedge; returns at the negedge after the response pulse.
  task automatic do_txn(input bit we, input logic [31:0] addr, input logic [127:0] line,
                        input bit exp_err);
    int n;
    logic [127:0] exp_line;
    exp_addr  = addr & ~32'hF;
    exp_wline = line;
    req_we = we; req_addr = addr; req_wdata = line; req_valid = 1;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 0;
      return;
    end
    last_acc_edge = cyc + 1;
    if (we) begin
      for (int i = 0; i < LW; i++) ref_mem[widx(exp_addr + 32'(i*4))] = line[i*32 +: 32];
      exp_line = last_rd_line;
    end else begin
      exp_line = ref_line(exp_addr);
    end
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 500);
    if (!resp_valid) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    last_resp_edge = cyc;
    if (we) begin
      chk("wr_err", resp_err, exp_err);
      chk("rdata_hold", resp_rdata, exp_line);
    end else begin
      chk("rd_err", resp_err, exp_err);
      chk("rd_line", resp_rdata, exp_line);
      last_rd_line = exp_line;
    end
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);
  endtask

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int n, p0, prev_resp;
    logic [127:0] line;
    rst_n = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 4096; i++) begin
      smem[i] = $urandom;
      ref_mem[i] = smem[i];
    end
    #2 rst_n = 0;
    #1;
    chk("rst_outs", {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_rdata", resp_rdata, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    chk("ready_before_edge", req_ready, 0);
    @(posedge clk); #1;
    chk("ready_after_edge", req_ready, 1);
    @(negedge clk);

    for (int i = 0; i < LW; i++) begin
      smem[widx(32'h1000 + 32'(i*4))]    = 32'hA0 + 32'(i);
      ref_mem[widx(32'h1000 + 32'(i*4))] = 32'hA0 + 32'(i);
    end
    do_txn(0, 32'h1004, 0, 0);
    chk("rd0_const", resp_rdata, 128'h000000A3_000000A2_000000A1_000000A0);

    aw_delay = 5; w_toggle = 1;
    do_txn(1, 32'h1040, rnd_line(), 0);
    aw_delay = 0; w_toggle = 0;
    do_txn(0, 32'h1040, 0, 0);

    aw_after_w = 1;
    do_txn(1, 32'h1080, rnd_line(), 0);
    aw_after_w = 0;
    do_txn(0, 32'h1088, 0, 0);

    rerr_beat = 1;
    p0 = rhs;
    do_txn(0, 32'h1000, 0, 1);
    chk("rerr_beats", rhs - p0, 4);
    rerr_beat = -1;

    bresp_val = 2'b11;
    do_txn(1, 32'h10C0, rnd_line(), 1);
    bresp_val = 2'b00;

    early_beat = 2;
    do_txn(0, 32'h1040, 0, 1);
    early_beat = -1;
    do_txn(0, 32'h10C0, 0, 0);

    line = rnd_line();
    do_txn(1, 32'h2000, line, 0);
    prev_resp = last_resp_edge;
    do_txn(0, 32'h2000, 0, 0);
    chk("b2b_gap", last_acc_edge - prev_resp, 2);
    chk("b2b_data", resp_rdata, line);

    exp_addr = 32'h1000; req_we = 0; req_addr = 32'h1000; req_valid = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 0;
    n = 0;
    while (!(rbeat == 2 && rvalid) && n < 100) begin @(negedge clk); n++; end
    if (!(rbeat == 2 && rvalid)) chk("beat2_timeout", 0, 1);
    p0 = pulses;
    #2 rst_n = 0;
    #1;
    chk("midrst_outs", {req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("midrst_rdata", resp_rdata, 0);
    last_rd_line = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_ready", req_ready, 1);
    repeat (10) @(negedge clk);
    chk("midrst_noresp", pulses - p0, 0);

    rand_stall = 1;
    for (int k = 0; k < 24; k++) begin
      do_txn(1'($urandom % 2), $urandom & 32'h3FFF, rnd_line(), 0);
    end
    rand_stall = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_line_master.md
# axi_line_master

Cache-line AXI4 master bridge between the core's cache refill/writeback port and the AXI4 memory slave (`axi_ram`). It accepts one line-sized read or write request and issues exactly one INCR burst of `LINE_WORDS` beats. Read data is collected into a line register. Completion is signalled by a single-cycle response pulse. Only one transaction is in flight at a time.

## Interface
- `DATA_WIDTH`, 32: AXI data width.
- `ADDR_WIDTH`, 32: AXI / request address width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: bytes per beat.
- `ID_WIDTH`, 8: AXI ID width.
- `AXI_ID`, 0: constant driven on `arid`/`awid`.
- `LINE_WORDS`, 4: beats per line; must be a power of two, 1..256.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block idle and able to accept.
- `req_we`, in, 1: 1 = line write, 0 = line read.
- `req_addr`, in, `ADDR_WIDTH`: byte address; line-offset bits ignored.
- `req_wdata`, in, `LINE_WORDS*DATA_WIDTH`: write line; word 0 in the LSBs.
- `resp_valid`, out, 1: one-cycle completion pulse.
- `resp_err`, out, 1: valid with `resp_valid`; protocol or slave error.
- `resp_rdata`, out, `LINE_WORDS*DATA_WIDTH`: read line; word 0 in the LSBs.
- AXI4 master ports (`m_axi_` prefix), standard widths:
  - AW channel: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot`, `awvalid`, `awready`.
  - W channel: `wdata`, `wstrb`, `wlast`, `wvalid`, `wready`.
  - B channel: `bid`, `bresp`, `bvalid`, `bready`.
  - AR channel: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid`, `arready`.
  - R channel: `rid`, `rdata`, `rresp`, `rlast`, `rvalid`, `rready`.

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- **Reset (`rst_n` low):** all state and outputs clear asynchronously.
  - State = IDLE.
  - `req_ready`, `resp_valid`, `resp_err`, all AXI valid/ready outputs = 0.
  - `resp_rdata` = 0.
- **Exit from reset:** `req_ready` rises on the first clock edge after `rst_n` deasserts.
- **IDLE:** `req_ready`=1.
  - On `req_valid && req_ready`: latch `req_we`, the address and the write line, and clear the error flag.
  - Stored address = `req_addr` with its low log2(`LINE_WORDS*STRB_WIDTH`) bits zeroed.
  - Clear the beat counter; `req_ready` goes to 0.
  - Go to RD_ADDR if `req_we`=0, else WR.
- **Constant burst fields:**
  - `len` = `LINE_WORDS-1`; `size` = log2(`STRB_WIDTH`); `burst` = 2'b01 (INCR).
  - `lock` = 0; `cache` = 4'b0011; `prot` = 3'b000; `wstrb` = all ones.
- **RD_ADDR:** `arvalid`=1 with the stored address. On `arready`, go to RD_DATA.
- **RD_DATA:** `rready`=1.
  - Each `rvalid` beat is written into word[counter] of `resp_rdata`, then the counter increments.
  - Any `rresp != 0` sets the error flag (sticky).
  - `rlast` on a beat other than counter = `LINE_WORDS-1` sets the error flag. Missing `rlast` on the final beat also sets it.
  - Completion is decided by the count, not `rlast`: after beat `LINE_WORDS-1`, go to DONE.
- **WR:** `awvalid` and `wvalid` are asserted together on the cycle WR is entered.
  - AW and W complete independently. `awvalid` drops after its handshake.
  - `wdata` = line word[counter]; `wlast` = (counter == `LINE_WORDS-1`).
  - The counter increments on each W handshake; `wvalid` drops after the last beat.
  - When AW has completed and the last W beat has been accepted (in either order or the same cycle), go to WR_RESP.
- **WR_RESP:** `bready`=1. On `bvalid`, the error flag |= (`bresp != 0`); go to DONE.
- **DONE:** `resp_valid`=1 for exactly one cycle, with `resp_err` = error flag. Return to IDLE.
  - `req_ready` returns to 1 the cycle after DONE.
  - No backpressure on the response.
- **`resp_rdata` hold:** holds its value until the next read overwrites it. Writes do not modify it.
- **Ignored inputs:** `rid` and `bid`.
- **Reset mid-transaction:** aborts immediately. All valids drop and no response is produced. The slave must be reset concurrently.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- AXI valid/payload rule: once asserted, a valid stays high with its payload stable until its ready is sampled high.
- **Read latency** (accept at edge 0):
  - `arvalid` is high in cycle 1.
  - `resp_valid` is high the cycle after the last R handshake.
  - With `arready` high in cycle 1 and back-to-back R beats starting in cycle 3, `resp_valid` is high in cycle 3+`LINE_WORDS`.
- **Write latency:**
  - `awvalid`/`wvalid` are high in cycle 1.
  - `bready` is high from the cycle after the final AW/W handshake.
  - `resp_valid` is high the cycle after the B handshake.
- **Back-to-back requests:** minimum spacing between request acceptances is the transaction time + 2 cycles (DONE, then IDLE).

## Test plan
- **Read, zero-wait:**
  - Stimulus: memory words 0x1000..0x100C = 0xA0, 0xA1, 0xA2, 0xA3; read `req_addr`=0x1004.
  - Required: `araddr`=0x1000, `arlen`=3; `resp_rdata`={0xA3,0xA2,0xA1,0xA0}; `resp_err`=0; `resp_valid` one cycle wide.
- **Write with stalls:**
  - Stimulus: `awready` held low 5 cycles; `wready` toggling 1,0,1,0.
  - Required: all 4 beats arrive in order; `wlast` only on beat 3; a readback matches; AW and W payloads stay stable while stalled.
- **AW after W:**
  - Stimulus: `awready` withheld until after all W beats are accepted.
  - Required: `bready` asserts only after the AW handshake; a single `resp_valid`.
- **Errors:**
  - Read with `rresp`=2'b10 on beat 1 -> `resp_err`=1, all 4 beats still consumed.
  - Write with `bresp`=2'b11 -> `resp_err`=1.
  - Early `rlast` on beat 2 -> `resp_err`=1.
- **Reset mid-burst:**
  - Stimulus: assert `rst_n`=0 during R beat 2.
  - Required: all outputs 0 asynchronously (same cycle); `req_ready`=1 on the first edge after release; no `resp_valid`.
- **Back-to-back:**
  - Stimulus: write line 0x2000, then immediately read it.
  - Required: the second request is accepted exactly 2 cycles after the first `resp_valid`; read data equals the written line.
